// File: rtl/sync_cpi_monitor.sv
// sync_cpi_monitor: locks to the PMT sync CPI structure (short PRIs + one long PRI) and flags width, PRI and switch faults.
// Defining SYNC_MON_LOS_EN adds the loss-of-signal timeout (err_los); otherwise err_los is tied low.
module sync_cpi_monitor #(
`ifdef SYNC_MON_LOS_EN
    parameter int LOS_CLKS = 6000,
`endif
    parameter int PW_CLKS = 480,
    parameter int SHORT_CLKS = 2400,
    parameter int LONG_CLKS = 3000,
    parameter int CPI_LEN = 100,
    parameter int TOL = 4,
    parameter int SW_LEAD = 6,
    parameter int SW_TOL = 1,
    parameter int SW_SAMPLE = 240
) (
    input  logic       i_sysclk,
    input  logic [0:0] i_btn,
    input  logic       i_sync_in,
    input  logic       i_sw_in,
    output logic       o_locked,
    output logic       o_cpi_start,
    output logic       o_pulse_vld,
    output logic [6:0] o_pulse_idx,
    output logic       o_err_width,
    output logic       o_err_pri,
    output logic       o_err_switch,
    output logic [7:0] o_err_cnt,
    output logic       o_err_los
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_sy, r_sw;
    logic        r_sy_d, r_sw_d, r_per_vld, r_sw_seen;
    logic [15:0] r_per_cnt, r_lead_cnt;
    logic [11:0] r_hi_cnt;
    logic [16:0] w_per, w_hi, w_lead;
    logic [6:0]  w_idx_nxt;
    logic        w_rst, w_rise, w_fall, w_sw_rise, w_locked, w_last, w_long_ok, w_pri_ok;
    logic        w_e_pri, w_e_lead, w_e_width, w_e_level, w_los, w_any, w_start, w_vld;

    function automatic logic in_rng(input logic [16:0] v, input int nom, input int tol);
        return v >= 17'(nom - tol) && v <= 17'(nom + tol);
    endfunction

    assign w_rst     = i_btn[0];
    assign w_rise    = r_sy[1] & ~r_sy_d;
    assign w_fall    = ~r_sy[1] & r_sy_d;
    assign w_sw_rise = r_sw[1] & ~r_sw_d;
    // Counters hold (interval - 1) when sampled, so +1 gives true clock spans.
    assign w_per     = {1'b0, r_per_cnt} + 17'd1;
    assign w_hi      = {5'd0, r_hi_cnt} + 17'd1;
    assign w_lead    = {1'b0, r_lead_cnt} + 17'd1;
    assign w_locked  = r_state == LOCKED;
    assign o_locked  = w_locked;
    assign w_last    = o_pulse_idx == 7'(CPI_LEN - 1);
    assign w_long_ok = in_rng(w_per, LONG_CLKS, TOL);
    assign w_pri_ok  = w_last ? w_long_ok : in_rng(w_per, SHORT_CLKS, TOL);
    assign w_e_pri   = w_locked & w_rise & ~w_pri_ok;
    assign w_e_lead  = w_locked & w_rise & o_pulse_idx[0] & ~(r_sw_seen & in_rng(w_lead, SW_LEAD, SW_TOL));
    assign w_e_width = w_locked & w_fall & ~in_rng(w_hi, PW_CLKS, TOL);
    assign w_e_level = w_locked & (r_per_cnt == 16'(SW_SAMPLE)) & (r_sw[1] == o_pulse_idx[0]);
    assign w_any     = w_e_pri | w_e_lead | w_e_width | w_e_level | w_los;

`ifdef SYNC_MON_LOS_EN
    assign w_los = ~w_rise & (r_per_cnt == 16'(LOS_CLKS));
    always_ff @(posedge i_sysclk) begin
        if (w_rst) o_err_los <= 1'b0;
        else       o_err_los <= o_err_los | w_los;
    end
`else
    assign w_los     = 1'b0;
    assign o_err_los = 1'b0;
`endif

    always_ff @(posedge i_sysclk) begin
        if (w_rst) r_state <= HUNT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = o_pulse_idx;
        w_start     = 1'b0;
        w_vld       = 1'b0;
        if (w_los) begin
            w_state_nxt = HUNT;
            w_idx_nxt   = '0;
        end
        if (w_rise) begin
            if (!w_locked) begin
                if (r_per_vld && w_long_ok) begin
                    w_state_nxt = LOCKED;
                    w_idx_nxt   = '0;
                    w_start     = 1'b1;
                    w_vld       = 1'b1;
                end
            end else if (w_pri_ok) begin
                w_idx_nxt = w_last ? 7'd0 : o_pulse_idx + 7'd1;
                w_start   = w_last;
                w_vld     = 1'b1;
            end else begin
                w_state_nxt = HUNT;
                w_idx_nxt   = '0;
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (w_rst) begin
            r_sy         <= '0;
            r_sw         <= '0;
            r_sy_d       <= 1'b0;
            r_sw_d       <= 1'b0;
            r_per_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_lead_cnt   <= '0;
            r_sw_seen    <= 1'b0;
            r_per_vld    <= 1'b0;
            o_pulse_idx  <= '0;
            o_cpi_start  <= 1'b0;
            o_pulse_vld  <= 1'b0;
            o_err_width  <= 1'b0;
            o_err_pri    <= 1'b0;
            o_err_switch <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            r_sy         <= {r_sy[0], i_sync_in};
            r_sw         <= {r_sw[0], i_sw_in};
            r_sy_d       <= r_sy[1];
            r_sw_d       <= r_sw[1];
            r_per_cnt    <= w_rise ? 16'd0 : r_per_cnt + {15'd0, ~&r_per_cnt};
            r_hi_cnt     <= w_rise ? 12'd0 : r_hi_cnt + {11'd0, r_sy[1] & ~&r_hi_cnt};
            r_lead_cnt   <= w_sw_rise ? 16'd0 : r_lead_cnt + {15'd0, ~&r_lead_cnt};
            // A switch rise coincident with the sync rise belongs to the new pulse.
            r_sw_seen    <= w_rise ? w_sw_rise : r_sw_seen | w_sw_rise;
            r_per_vld    <= w_los ? 1'b0 : r_per_vld | w_rise;
            o_pulse_idx  <= w_idx_nxt;
            o_cpi_start  <= w_start;
            o_pulse_vld  <= w_vld;
            o_err_width  <= o_err_width | w_e_width;
            o_err_pri    <= o_err_pri | w_e_pri;
            o_err_switch <= o_err_switch | w_e_lead | w_e_level;
            o_err_cnt    <= o_err_cnt + {7'd0, w_any & ~&o_err_cnt};
        end
    end
endmodule
